// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int INSTR_WIDTH = 32;
  localparam int OP_LSB      = 0;
  localparam int FUNCT3_LSB  = 12;
  localparam int FUNCT7_BIT  = 30;
  localparam int PC_INCR     = 4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with occupancy count and clear
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted when the head leaves on the same edge.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, imem request/response, instruction buffer and redirect flush
// Optional misaligned-redirect flag fetch_err is built when FETCH_MISALIGN_CHECK_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'h0000_0000,
  parameter int                       BUF_DEPTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_instr,
  output logic [ADDRESS_WIDTH-1:0] dec_pc,
  output logic [6:0]               dec_op,
  output logic [2:0]               dec_funct3,
  output logic                     dec_funct7
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                     fetch_err
`endif
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int SW = CW + 1;

  localparam logic [1:0] S_RESET = RESET;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_FLUSH = FLUSH;

  logic [1:0]                state;
  logic [AW-1:0]             fetch_pc;
  logic [CW-1:0]             stale_cnt;
  logic [CW-1:0]             stale_base;
  logic [CW-1:0]             stale_next;
  logic [CW-1:0]             buf_count;
  logic [CW-1:0]             tag_count;
  logic [AW-1:0]             tag_rdata;
  logic [INSTR_WIDTH+AW-1:0] buf_rdata;
  logic [SW-1:0]             credit_used;
  logic                      gnt_fire;
  logic                      dec_fire;
  logic                      rsp_keep;

  assign dec_valid   = (buf_count != '0);
  assign dec_fire    = dec_valid && dec_ready;
  // A slot freed by this cycle's consume may be reissued immediately for full throughput.
  assign credit_used = SW'(buf_count) + SW'(tag_count) - SW'(dec_fire);
  assign imem_req    = (state == S_RUN) && (credit_used < SW'(BUF_DEPTH));
  assign imem_addr   = fetch_pc;
  assign gnt_fire    = imem_req && imem_gnt;
  assign rsp_keep    = (state == S_RUN) && imem_rvalid && !redirect_valid;

  // Requests still owed by memory after this edge; a response landing now is already paid off.
  always_comb begin
    stale_base = '0;
    if (state == S_RUN) begin
      stale_base = tag_count + CW'(gnt_fire);
    end else if (state == S_FLUSH) begin
      stale_base = stale_cnt;
    end
    stale_next = (imem_rvalid && (stale_base != '0)) ? stale_base - CW'(1) : stale_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET;
      fetch_pc  <= RESET_PC;
      stale_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc  <= {redirect_pc[AW-1:2], 2'b00};
      stale_cnt <= stale_next;
      state     <= (stale_next != '0) ? S_FLUSH : S_RUN;
    end else begin
      if (gnt_fire) begin
        fetch_pc <= fetch_pc + AW'(PC_INCR);
      end
      if (state == S_FLUSH) begin
        stale_cnt <= stale_next;
        if (stale_next == '0) begin
          state <= S_RUN;
        end
      end else if (state == S_RESET) begin
        state <= S_RUN;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (AW),
    .DEPTH (BUF_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (redirect_valid),
    .push  (gnt_fire && !redirect_valid),
    .wdata (fetch_pc),
    .pop   (rsp_keep),
    .rdata (tag_rdata),
    .count (tag_count)
  );

  fetch_fifo #(
    .WIDTH (INSTR_WIDTH + AW),
    .DEPTH (BUF_DEPTH)
  ) u_buf_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (redirect_valid),
    .push  (rsp_keep),
    .wdata ({imem_rdata, tag_rdata}),
    .pop   (dec_fire),
    .rdata (buf_rdata),
    .count (buf_count)
  );

  assign dec_instr  = buf_rdata[INSTR_WIDTH+AW-1:AW];
  assign dec_pc     = buf_rdata[AW-1:0];
  assign dec_op     = dec_instr[OP_LSB +: 7];
  assign dec_funct3 = dec_instr[FUNCT3_LSB +: 3];
  assign dec_funct7 = dec_instr[FUNCT7_BIT];

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fetch_err <= 1'b1;
    end
  end
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
`endif

endmodule
